l1_mem_arbiter: RTL

Two-port arbiter sharing the single next-level memory port between the L1 instruction cache and the L1 data cache miss/write-back paths. Each cache controller presents a line request (address, read/write, write line) and holds it until it sees its ready pulse. The arbiter selects one requester with round-robin fairness, latches and forwards its request, and routes the memory response back to the granted cache only. Saturating counters expose grants and contention for performance monitoring, alongside the caches' own access/hit/miss counters.

---
 rtl/l1_mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one next-level memory port between the L1 I-cache and D-cache.
// Latches the winning request, routes the memory response to the granted cache only, and keeps saturating perf counters.
module l1_mem_arbiter #(
  parameter int          ADDR_W   = 32,
  parameter int          LINE_W   = 128,
  // Counter preset applied on reset; leave at zero for normal operation.
  parameter logic [31:0] CNT_INIT = 32'd0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  input  logic              ic_req_rw_i,
  input  logic [LINE_W-1:0] ic_req_wdata_i,
  output logic [LINE_W-1:0] ic_res_data_o,
  output logic              ic_res_ready_o,
  input  logic              dc_req_valid_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic              dc_req_rw_i,
  input  logic [LINE_W-1:0] dc_req_wdata_i,
  output logic [LINE_W-1:0] dc_res_data_o,
  output logic              dc_res_ready_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_rw_o,
  output logic [LINE_W-1:0] mem_req_wdata_o,
  input  logic [LINE_W-1:0] mem_res_data_i,
  input  logic              mem_res_ready_i,
  output logic [1:0]        grant_o,
  output logic [31:0]       ic_grants_o,
  output logic [31:0]       dc_grants_o,
  output logic [31:0]       conflict_cnt_o
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  state_t            state_reg, state_next;
  logic              last_grant_d_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rw_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic [31:0]       ic_grants_reg, dc_grants_reg, conflict_reg;
  logic              pick_i, pick_d, both_valid;

  assign both_valid = ic_req_valid_i & dc_req_valid_i;

  always_comb begin
    state_next = state_reg;
    pick_i     = 1'b0;
    pick_d     = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (ic_req_valid_i && (!dc_req_valid_i || last_grant_d_reg)) begin
          pick_i     = 1'b1;
          state_next = GRANT_I;
        end else if (dc_req_valid_i) begin
          pick_d     = 1'b1;
          state_next = GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_res_ready_i) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg        <= IDLE;
      last_grant_d_reg <= 1'b1;
      addr_reg         <= '0;
      rw_reg           <= 1'b0;
      wdata_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (pick_i) begin
        addr_reg         <= ic_req_addr_i;
        rw_reg           <= ic_req_rw_i;
        wdata_reg        <= ic_req_wdata_i;
        last_grant_d_reg <= 1'b0;
      end else if (pick_d) begin
        addr_reg         <= dc_req_addr_i;
        rw_reg           <= dc_req_rw_i;
        wdata_reg        <= dc_req_wdata_i;
        last_grant_d_reg <= 1'b1;
      end
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ic_grants_reg <= CNT_INIT;
      dc_grants_reg <= CNT_INIT;
      conflict_reg  <= CNT_INIT;
    end else begin
      if (pick_i && ic_grants_reg != 32'hFFFF_FFFF) ic_grants_reg <= ic_grants_reg + 32'd1;
      if (pick_d && dc_grants_reg != 32'hFFFF_FFFF) dc_grants_reg <= dc_grants_reg + 32'd1;
      if ((pick_i || pick_d) && both_valid && conflict_reg != 32'hFFFF_FFFF)
        conflict_reg <= conflict_reg + 32'd1;
    end
  end

  assign grant_o         = {state_reg == GRANT_D, state_reg == GRANT_I};
  assign mem_req_valid_o = grant_o[0] | grant_o[1];
  assign mem_req_addr_o  = addr_reg;
  assign mem_req_rw_o    = rw_reg;
  assign mem_req_wdata_o = wdata_reg;

  assign ic_res_ready_o = grant_o[0] & mem_res_ready_i;
  assign dc_res_ready_o = grant_o[1] & mem_res_ready_i;
  assign ic_res_data_o  = grant_o[0] ? mem_res_data_i : '0;
  assign dc_res_data_o  = grant_o[1] ? mem_res_data_i : '0;

  assign ic_grants_o    = ic_grants_reg;
  assign dc_grants_o    = dc_grants_reg;
  assign conflict_cnt_o = conflict_reg;

endmodule
